// File: rtl/counter_pkg.sv
// Shared definitions for the free-running up-counter: default width and the
// wrap-aware increment used to compute the next count.
package counter_pkg;

    // Default counter width when the instantiating level does not override it.
    localparam int unsigned CNT_WIDTH_DEF = 4;

    // Next count after one rising edge. Any value at or above max, including an
    // out-of-range value left by an upset, returns to rst_val. Every other value
    // steps up by one. The arguments are 32 bits wide so that every counter width
    // can share this one function.
    function automatic logic [31:0] next_count(
        input logic [31:0] q,
        input logic [31:0] max,
        input logic [31:0] rst_val
    );
        logic [31:0] result;
        if (q >= max) begin
            result = rst_val;
        end else begin
            result = q + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_up_counter_cnt_reg.sv
// Count register: a WIDTH-bit register with an asynchronous active-low clear.
// The clear loads RESET_VALUE instead of zero.
module cnt_reg
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = CNT_WIDTH_DEF,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State register: the clear acts immediately. Otherwise load the next count on every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= WIDTH'(RESET_VALUE);
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/sync_up_counter.sv
// Free-running synchronous up-counter. It counts from RESET_VALUE up to
// MAX_COUNT and then wraps. tc flags the terminal count.
module sync_up_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH       = CNT_WIDTH_DEF,
    parameter int unsigned MAX_COUNT   = (1 << WIDTH) - 1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Q,
    output logic             tc
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_next;

    // Next-state decode: increment, or wrap to RESET_VALUE at or beyond MAX_COUNT.
    always_comb begin
        count_next = WIDTH'(next_count(32'(count), 32'(MAX_COUNT), 32'(RESET_VALUE)));
    end

    cnt_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_cnt_reg (
        .clk (clk),
        .rst (rst),
        .d   (count_next),
        .q   (count)
    );

    // The terminal count is decoded only from the registered value. It therefore
    // changes once per edge together with Q and tracks the clear during reset.
    always_comb begin
        tc = (count == WIDTH'(MAX_COUNT));
    end

    assign Q = count;

endmodule

// File: tb/tb_sync_up_counter.sv
// Bench for sync_up_counter. The model tracks the number of edges seen with
// reset released since the last reset. It computes the expected count as
// RESET_VALUE + steps mod period.
module tb_sync_up_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst2;
    logic [3:0] q;
    logic       tc;
    logic [2:0] q2;
    logic       tc2;

    int n_cmp = 0;
    int n_err = 0;
    int k     = 0;   // edges with rst=1 since last reset, default instance
    int k2    = 0;   // same, variant instance
    int tc_cnt;
    int hold;

    always #5 clk = ~clk;

    sync_up_counter #(.WIDTH(4), .MAX_COUNT(15), .RESET_VALUE(0)) dut (
        .clk (clk), .rst (rst), .Q (q), .tc (tc)
    );

    sync_up_counter #(.WIDTH(3), .MAX_COUNT(5), .RESET_VALUE(2)) dut_v (
        .clk (clk), .rst (rst2), .Q (q2), .tc (tc2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_q(input int rv, input int mx, input int steps);
        return rv + (steps % (mx - rv + 1));
    endfunction

    task automatic check_main(input string tag);
        check_val({tag, "_q"}, 32'(q), 32'(exp_q(0, 15, k)));
        check_val({tag, "_tc"}, 32'(tc), 32'(exp_q(0, 15, k) == 15));
    endtask

    // One clock cycle: advance the model on the rising edge and return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst === 1'b1) k++;
        if (rst2 === 1'b1) k2++;
        @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        #2;
        rst  = 1'b0;
        rst2 = 1'b0;
        #1;
        k  = 0;
        k2 = 0;
        check_main("por_async");

        // Power-on reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            check_main("por_hold");
        end
        rst = 1'b1;

        // Full sweep of 20 cycles: 1..15, 0, 1..4
        for (int i = 0; i < 20; i++) begin
            tick();
            check_main("sweep");
        end

        // Run on to Q=7, then drop rst between edges
        while ((k % 16) != 7) begin
            tick();
            check_main("to7");
        end
        #2;
        rst = 1'b0;
        #1;
        k = 0;
        check_val("mid_async_q", 32'(q), 32'd0);
        tick();
        check_main("mid_hold");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_main("mid_restart");
        end

        // Reset held across ten edges
        rst = 1'b0;
        k   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_main("long_hold");
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_main("post_hold");
        end

        // Reset asserted exactly at a rising edge: reset wins
        @(posedge clk);
        rst = 1'b0;
        #1;
        k = 0;
        check_val("edge_rst_q", 32'(q), 32'd0);
        @(negedge clk);
        check_main("edge_rst_hold");
        rst = 1'b1;

        // Long uninterrupted run, counting terminal-count cycles
        tc_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            check_main("long");
            if (tc === 1'b1) tc_cnt++;
        end
        check_val("tc_count_in_range", 32'(tc_cnt >= 61 && tc_cnt <= 63), 32'd1);

        // Random asynchronous resets at arbitrary count values
        for (int i = 0; i < 300; i++) begin
            tick();
            check_main("rand");
            if ($urandom_range(0, 19) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                k = 0;
                check_val("rand_async_q", 32'(q), 32'd0);
                hold = int'($urandom_range(1, 3));
                for (int j = 0; j < hold; j++) begin
                    tick();
                    check_main("rand_hold");
                end
                rst = 1'b1;
            end
        end

        // Variant instance: WIDTH=3, range 2..5, period 4
        check_val("var_rst_q", 32'(q2), 32'd2);
        check_val("var_rst_tc", 32'(tc2), 32'd0);
        rst2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("var_q", 32'(q2), 32'(exp_q(2, 5, k2)));
            check_val("var_tc", 32'(tc2), 32'(exp_q(2, 5, k2) == 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
